// File: rtl/fourier_sched.sv
// rtl/fourier_sched.sv - N-point DFT issue sequencer: (k,n) loop walk, (k*n) mod N twiddle, result collection.
// Optional conjugate-twiddle mode under `FOURIER_SCHED_INVERSE_EN (adds the `inverse` input).
module fourier_sched #(
  parameter int N     = 10,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef FOURIER_SCHED_INVERSE_EN
  input  logic             inverse,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mac_valid,
  input  logic             mac_ready,
  output logic [IDX_W-1:0] smp_addr,
  output logic [IDX_W-1:0] tw_addr,
  output logic             mac_first,
  output logic             mac_last,
  input  logic             res_valid,
  output logic             res_wr_en,
  output logic [IDX_W-1:0] res_wr_addr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] N_W   = IDX_W'(N);
  localparam logic [IDX_W:0]   N_EXT = (IDX_W + 1)'(N);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic [IDX_W-1:0] tw_q, tw_d;
  logic [IDX_W-1:0] res_cnt_q, res_cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
`ifdef FOURIER_SCHED_INVERSE_EN
  logic             inv_q, inv_d;
`endif

  logic [IDX_W:0]   tw_sum;
  logic [IDX_W:0]   tw_sub;
  logic [IDX_W-1:0] tw_next;
  logic [IDX_W-1:0] tw_out;
  logic             issue;
  logic             res_hit;

  // Incremental twiddle: tw tracks (k*n) mod N by adding k each step, wrapping once.
  always_comb begin
    tw_sum  = {1'b0, tw_q} + {1'b0, k_q};
    tw_sub  = tw_sum - N_EXT;
    tw_next = (tw_sum >= N_EXT) ? tw_sub[IDX_W-1:0] : tw_sum[IDX_W-1:0];
  end

  always_comb begin
    issue   = (state_q == S_RUN) && mac_ready;
    res_hit = res_valid && (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      n_q       <= '0;
      tw_q      <= '0;
      res_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef FOURIER_SCHED_INVERSE_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      n_q       <= n_d;
      tw_q      <= tw_d;
      res_cnt_q <= res_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef FOURIER_SCHED_INVERSE_EN
      inv_q     <= inv_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    n_d       = n_q;
    tw_d      = tw_q;
    res_cnt_d = res_cnt_q;
    done_d    = done_q;
    err_d     = err_q;
`ifdef FOURIER_SCHED_INVERSE_EN
    inv_d     = inv_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          k_d       = '0;
          n_d       = '0;
          tw_d      = '0;
          res_cnt_d = '0;
          done_d    = 1'b0;
          err_d     = 1'b0;
`ifdef FOURIER_SCHED_INVERSE_EN
          inv_d     = inverse;
`endif
        end else if (res_valid) begin
          err_d = 1'b1;
        end
      end
      S_RUN: begin
        if (issue) begin
          if (n_q == LAST) begin
            n_d  = '0;
            tw_d = '0;
            k_d  = k_q + 1'b1;
            if (k_q == LAST) begin
              state_d = S_DRAIN;
            end
          end else begin
            n_d  = n_q + 1'b1;
            tw_d = tw_next;
          end
        end
      end
      S_DRAIN: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result collection runs in RUN and DRAIN alike; the final bin ends the run.
    if (res_hit) begin
      res_cnt_d = res_cnt_q + 1'b1;
      if (res_cnt_q == LAST) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end
  end

`ifdef FOURIER_SCHED_INVERSE_EN
  always_comb begin
    tw_out = tw_q;
    if (inv_q && (tw_q != '0)) begin
      tw_out = N_W - tw_q;
    end
  end
`else
  always_comb begin
    tw_out = tw_q;
  end
`endif

  // Every output is forced low while reset is asserted, even mid-run.
  always_comb begin
    busy        = !reset && (state_q != S_IDLE);
    done        = !reset && done_q;
    err         = !reset && err_q;
    mac_valid   = !reset && (state_q == S_RUN);
    smp_addr    = mac_valid ? n_q : '0;
    tw_addr     = mac_valid ? tw_out : '0;
    mac_first   = mac_valid && (n_q == '0);
    mac_last    = mac_valid && (n_q == LAST);
    res_wr_en   = !reset && res_hit;
    res_wr_addr = reset ? '0 : res_cnt_q;
  end

endmodule

// File: tb/tb_fourier_sched.sv
// tb/tb_fourier_sched.sv - randomized bench for fourier_sched against a (k*n) mod N issue/result model.
module tb_fourier_sched;
  localparam int N     = 10;
  localparam int IDX_W = 5;
  localparam int LAT   = 3;
  localparam int NN    = N * N;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             inverse;
  logic             busy, done, err;
  logic             mac_valid, mac_ready;
  logic [IDX_W-1:0] smp_addr, tw_addr;
  logic             mac_first, mac_last;
  logic             res_valid;
  logic             res_wr_en;
  logic [IDX_W-1:0] res_wr_addr;

  int checks   = 0;
  int failures = 0;
  int cap_tw[NN];

  fourier_sched #(.N(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef FOURIER_SCHED_INVERSE_EN
    .inverse(inverse),
`endif
    .busy(busy), .done(done), .err(err),
    .mac_valid(mac_valid), .mac_ready(mac_ready),
    .smp_addr(smp_addr), .tw_addr(tw_addr),
    .mac_first(mac_first), .mac_last(mac_last),
    .res_valid(res_valid), .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr)
  );

  always #5 clk = ~clk;

  // One transform: start pulse, random readiness, LAT-cycle MAC model; optional reset abort or stray start.
  task automatic run_xfer(input int ready_pct, input int abort_at, input int start_at, input bit inv, input string tag);
    int idx, rcnt, c, last_issue_c, k, n, t;
    int due[$];
    idx = 0; rcnt = 0; c = 0; last_issue_c = -1;
    due.delete();
    @(posedge clk); #1;
    start = 1'b1; inverse = inv; mac_ready = 1'b0; res_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; inverse = 1'b0; c = 1;
    mac_ready = ($urandom_range(99) < ready_pct);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mac_valid !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL %s start_latency: busy=%b mac_valid=%b done=%b err=%b required 1 1 0 0", tag, busy, mac_valid, done, err);
    end
    for (int guard = 0; guard < 3000; guard++) begin
      checks++;
      if (res_wr_en !== res_valid) begin
        failures++;
        $display("FAIL %s res_wr_en: got %b required %b (cycle %0d)", tag, res_wr_en, res_valid, c);
      end
      if (res_valid) begin
        checks++;
        if (res_wr_addr !== IDX_W'(rcnt)) begin
          failures++;
          $display("FAIL %s res_wr_addr: got %0d required %0d", tag, res_wr_addr, rcnt);
        end
        rcnt++;
      end
      checks++;
      if (mac_valid !== (idx < NN)) begin
        failures++;
        $display("FAIL %s mac_valid: got %b required %b (issued %0d)", tag, mac_valid, idx < NN, idx);
      end
      if (mac_valid && idx < NN) begin
        k = idx / N; n = idx % N;
        t = (k * n) % N;
        if (inv) t = (N - t) % N;
        checks++;
        if (smp_addr !== IDX_W'(n) || tw_addr !== IDX_W'(t) ||
            mac_first !== (n == 0) || mac_last !== (n == N - 1)) begin
          failures++;
          $display("FAIL %s issue[%0d]: smp=%0d tw=%0d first=%b last=%b required smp=%0d tw=%0d first=%b last=%b",
                   tag, idx, smp_addr, tw_addr, mac_first, mac_last, n, t, n == 0, n == N - 1);
        end
        if (mac_ready) begin
          cap_tw[idx] = int'(tw_addr);
          if (n == N - 1) due.push_back(c + LAT);
          last_issue_c = c;
          idx++;
        end
      end
      if (rcnt == N) begin
        @(posedge clk); #1;
        res_valid = 1'b0; mac_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || mac_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s completion: busy=%b done=%b mac_valid=%b required 0 1 0", tag, busy, done, mac_valid);
        end
        if (ready_pct >= 100) begin
          checks++;
          if (last_issue_c != NN) begin
            failures++;
            $display("FAIL %s no_bubble: last issue at cycle %0d required %0d", tag, last_issue_c, NN);
          end
        end
        return;
      end
      @(posedge clk); #1;
      c++;
      start = (start_at >= 0 && idx == start_at);
      if (abort_at >= 0 && idx == abort_at) begin
        reset = 1'b1; res_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mac_valid !== 1'b0 || busy !== 1'b0 || res_wr_en !== 1'b0) begin
          failures++;
          $display("FAIL %s in_reset: mac_valid=%b busy=%b res_wr_en=%b required 0", tag, mac_valid, busy, res_wr_en);
        end
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; mac_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mac_valid !== 1'b0 || done !== 1'b0) begin
          failures++;
          $display("FAIL %s after_abort: busy=%b mac_valid=%b done=%b required 0 0 0", tag, busy, mac_valid, done);
        end
        return;
      end
      mac_ready = ($urandom_range(99) < ready_pct);
      res_valid = (due.size() > 0 && due[0] == c);
      if (res_valid) void'(due.pop_front());
      @(negedge clk);
    end
    failures++;
    $display("FAIL %s timeout: issued %0d results %0d", tag, idx, rcnt);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; inverse = 1'b0; mac_ready = 1'b0; res_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, err, mac_valid, res_wr_en} !== 5'b0) begin
      failures++;
      $display("FAIL reset_state: busy/done/err/valid/wr=%b required 00000", {busy, done, err, mac_valid, res_wr_en});
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int row3[10] = '{0, 3, 6, 9, 2, 5, 8, 1, 4, 7};
    int row5[10] = '{0, 5, 0, 5, 0, 5, 0, 5, 0, 5};
    run_xfer(100, -1, -1, 1'b0, "basic");
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cap_tw[30 + i] != row3[i] || cap_tw[50 + i] != row5[i] || cap_tw[i] != 0) begin
        failures++;
        $display("FAIL rows n=%0d: k0=%0d k3=%0d k5=%0d required 0 %0d %0d", i, cap_tw[i], cap_tw[30 + i], cap_tw[50 + i], row3[i], row5[i]);
      end
    end
  endtask

  task automatic test_stall();
    run_xfer(50, -1, -1, 1'b0, "stall");
  endtask

  task automatic test_abort_restart();
    run_xfer(100, 37, -1, 1'b0, "abort");
    run_xfer(100, -1, -1, 1'b0, "restart");
  endtask

  task automatic test_start_busy();
    run_xfer(70, -1, 50, 1'b0, "start_busy");
  endtask

  task automatic test_idle_res();
    @(posedge clk); #1;
    res_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (res_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_res_write: res_wr_en=%b required 0", res_wr_en);
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_res_err: err=%b done=%b busy=%b required 1 1 0", err, done, busy);
    end
    run_xfer(80, -1, -1, 1'b0, "clear_flags");
  endtask

`ifdef FOURIER_SCHED_INVERSE_EN
  task automatic test_inverse();
    int row3i[10] = '{0, 7, 4, 1, 8, 5, 2, 9, 6, 3};
    run_xfer(60, -1, -1, 1'b1, "inverse");
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cap_tw[30 + i] != row3i[i]) begin
        failures++;
        $display("FAIL inverse_row3 n=%0d: got %0d required %0d", i, cap_tw[30 + i], row3i[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_abort_restart();
    test_start_busy();
    test_idle_res();
`ifdef FOURIER_SCHED_INVERSE_EN
    test_inverse();
    run_xfer(100, -1, -1, 1'b0, "forward_after_inverse");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
